// File: rtl/fp_mult_pkg.sv
// Shared constants, special-case encodings and stage payloads for the FP multiplier datapath.
package fp_mult_pkg;

  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned WORD_W = 32;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic signed [EXP_W-1:0] EXP_MAX_E = EXP_W'(EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_ZERO  = EXP_W'(0);

  localparam logic [WORD_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    SP_NORM = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF  = 2'b10,
    SP_NAN  = 2'b11
  } special_e;

  // Normalized operand held between the normalize and round/pack stages
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              sticky;
    special_e          special;
  } norm_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even increment, carry renormalization and IEEE754 pack with exception flags.
module fp_rne_round
  import fp_mult_pkg::*;
(
  input  norm_t              norm,
  output logic [WORD_W-1:0]  result_c,
  output logic               ovf_c,
  output logic               uf_c,
  output logic               inexact_c
);

  logic                    round_up;
  logic [MANT_W:0]         m25;
  logic [MANT_W-1:0]       mant_r;
  logic                    carry;
  logic signed [EXP_W-1:0] exp_r;

  always_comb begin
    round_up = norm.guard & (norm.sticky | norm.mant[0]);
    m25      = {1'b0, norm.mant} + (MANT_W+1)'(round_up);
    carry    = m25[MANT_W];
    mant_r   = MANT_W'(m25);
    exp_r    = $signed(norm.exp) + (carry ? EXP_W'(1) : EXP_W'(0));

    result_c  = {norm.sign, exp_r[7:0], (carry ? 23'h0 : 23'(mant_r))};
    ovf_c     = 1'b0;
    uf_c      = 1'b0;
    inexact_c = norm.guard | norm.sticky;

    if (exp_r >= EXP_MAX_E) begin
      result_c  = {norm.sign, 8'hFF, 23'h0};
      ovf_c     = 1'b1;
      inexact_c = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      // No subnormal output: flush to signed zero
      result_c  = {norm.sign, 31'h0};
      uf_c      = 1'b1;
      inexact_c = 1'b1;
    end

    // Specials bypass the arithmetic and report no flags
    if (norm.special != SP_NORM) begin
      ovf_c     = 1'b0;
      uf_c      = 1'b0;
      inexact_c = 1'b0;
      case (norm.special)
        SP_ZERO: result_c = {norm.sign, 31'h0};
        SP_INF:  result_c = {norm.sign, 8'hFF, 23'h0};
        default: result_c = QNAN;
      endcase
    end
  end

endmodule

// File: rtl/fp_mul_norm_round.sv
// Normalize / round / pack back end of the single-precision multiplier; two-stage valid/ready pipeline.
module fp_mul_norm_round
  import fp_mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [1:0]        in_special,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic              out_ovf,
  output logic              out_uf,
  output logic              out_inexact
);

  logic              s1_valid;
  logic              s1_advance;
  norm_t             s1_d;
  norm_t             s1_q;
  logic [WORD_W-1:0] result_c;
  logic              ovf_c;
  logic              uf_c;
  logic              inexact_c;

  assign s1_advance = !out_valid | out_ready;
  assign in_ready   = !s1_valid | s1_advance;

  // Stage 1: align the leading one to the top of a 24-bit mantissa
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    if (in_prod[47]) begin
      s1_d.mant   = in_prod[47:24];
      s1_d.guard  = in_prod[23];
      s1_d.sticky = |in_prod[22:0];
      s1_d.exp    = in_exp + EXP_W'(1);
    end else begin
      s1_d.mant   = in_prod[46:23];
      s1_d.guard  = in_prod[22];
      s1_d.sticky = |in_prod[21:0];
      s1_d.exp    = in_exp;
    end
    if (special_e'(in_special) == SP_NORM && in_prod == '0) begin
      s1_d.special = SP_ZERO;
    end else begin
      s1_d.special = special_e'(in_special);
    end
  end

  fp_rne_round u_round (
    .norm      (s1_q),
    .result_c  (result_c),
    .ovf_c     (ovf_c),
    .uf_c      (uf_c),
    .inexact_c (inexact_c)
  );

  // Pipeline registers: a stage loads when empty or when its content moves on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_uf      <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s1_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_result  <= result_c;
          out_ovf     <= ovf_c;
          out_uf      <= uf_c;
          out_inexact <= inexact_c;
        end
      end
    end
  end

endmodule
